// File: rtl/data_mem_ctrl.sv
// Wait-state data memory for the multi-cycle CPU: byte/half/word loads and stores with
// alignment checks. Define DMEM_PARITY_EN to add per-byte even parity with read-time checking.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 128,
    parameter int ADDR_W      = 7,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        ready,
    output logic        err,
    output logic        perr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    function automatic logic reject_f(input logic rd, input logic wr,
                                      input logic [1:0] sz, input logic [1:0] lo);
        return (rd && wr) || (sz == 2'b11) || (sz == 2'b01 && lo[0]) ||
               (sz == 2'b10 && lo != 2'b00);
    endfunction

    function automatic logic [3:0] lane_en_f(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic par_f(input logic [7:0] b);
        return ^b;
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               rd_q, rd_d;
    logic [1:0]         size_q, size_d;
    logic               sext_q, sext_d;
    logic [ADDR_W+1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;
    logic               perr_q, perr_d;

    logic               acc_en_s;
    logic               acc_rd_s;
    logic               acc_wr_s;
    logic [1:0]         acc_size_s;
    logic               acc_sext_s;
    logic [ADDR_W+1:0]  acc_addr_s;
    logic [31:0]        acc_wdata_s;
    logic [ADDR_W-1:0]  idx_s;
    logic [3:0]         be_s;
    logic [31:0]        word_s;
    logic [31:0]        wlane_s;
    logic [31:0]        rd_val_s;
    logic [7:0]         byte_s;
    logic [15:0]        half_s;
    logic               par_bad_s;
    logic               unused_addr_s;

    logic [7:0]         mem_q [DEPTH_WORDS][4];

    assign unused_addr_s = ^addr[31:ADDR_W+2];

    // Sequencing: accept, wait-state countdown, and selection of the request that accesses memory
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        size_d      = size_q;
        sext_d      = sext_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = 1'b0;
        acc_en_s    = 1'b0;
        acc_rd_s    = rd_q;
        acc_size_s  = size_q;
        acc_sext_s  = sext_q;
        acc_addr_s  = addr_q;
        acc_wdata_s = wdata_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    acc_en_s = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_IDLE, S_DONE: begin
                if (mem_rd || mem_wr) begin
                    rd_d    = mem_rd;
                    size_d  = size;
                    sext_d  = sign_ext;
                    addr_d  = addr[ADDR_W+1:0];
                    wdata_d = wdata;
                    if (reject_f(mem_rd, mem_wr, size, addr[1:0])) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (WAIT_CYCLES == 0) begin
                        // zero wait states: the accept edge is also the access edge
                        acc_en_s    = 1'b1;
                        acc_rd_s    = mem_rd;
                        acc_size_s  = size;
                        acc_sext_s  = sign_ext;
                        acc_addr_s  = addr[ADDR_W+1:0];
                        acc_wdata_s = wdata;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Lane decode, store-data replication and load extraction for the access in progress
    always_comb begin
        idx_s    = acc_addr_s[ADDR_W+1:2];
        be_s     = lane_en_f(acc_size_s, acc_addr_s[1:0]);
        word_s   = {mem_q[idx_s][3], mem_q[idx_s][2], mem_q[idx_s][1], mem_q[idx_s][0]};
        byte_s   = 8'(word_s >> {acc_addr_s[1:0], 3'b000});
        half_s   = acc_addr_s[1] ? word_s[31:16] : word_s[15:0];
        case (acc_size_s)
            2'b00: begin
                wlane_s  = {4{acc_wdata_s[7:0]}};
                rd_val_s = acc_sext_s ? {{24{byte_s[7]}}, byte_s} : {24'h000000, byte_s};
            end
            2'b01: begin
                wlane_s  = {2{acc_wdata_s[15:0]}};
                rd_val_s = acc_sext_s ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
            end
            default: begin
                wlane_s  = acc_wdata_s;
                rd_val_s = word_s;
            end
        endcase
    end

`ifdef DMEM_PARITY_EN
    logic par_q [DEPTH_WORDS][4];
    logic vld_q [DEPTH_WORDS][4];

    // Parity check over the lanes being read; lanes never written are masked out
    always_comb begin
        par_bad_s = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (be_s[k] && vld_q[idx_s][k] && (par_q[idx_s][k] != par_f(mem_q[idx_s][k]))) begin
                par_bad_s = 1'b1;
            end else begin
                par_bad_s = par_bad_s;
            end
        end
    end

    // Parity and written-lane tracking, updated alongside the data lanes
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int w = 0; w < DEPTH_WORDS; w++) begin
                for (int k = 0; k < 4; k++) begin
                    vld_q[w][k] <= 1'b0;
                end
            end
        end else if (acc_wr_s) begin
            for (int k = 0; k < 4; k++) begin
                if (be_s[k]) begin
                    par_q[idx_s][k] <= par_f(wlane_s[k*8 +: 8]);
                    vld_q[idx_s][k] <= 1'b1;
                end
            end
        end
    end
`else
    assign par_bad_s = 1'b0;
`endif

    // Next values of the registered outputs
    always_comb begin
        acc_wr_s = acc_en_s && !acc_rd_s;
        busy_d   = (state_d == S_WAIT);
        ready_d  = (state_d == S_DONE);
        if (acc_en_s && acc_rd_s) begin
            rdata_d = rd_val_s;
            perr_d  = par_bad_s;
        end else begin
            rdata_d = rdata_q;
            perr_d  = 1'b0;
        end
    end

    // Control and output registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h00000000;
            rdata_q <= 32'h00000000;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            perr_q  <= perr_d;
        end
    end

    // Storage array: contents survive Reset, and a write is dropped if Reset hits its access edge
    always_ff @(posedge CLK) begin
        if (!Reset && acc_wr_s) begin
            for (int k = 0; k < 4; k++) begin
                if (be_s[k]) begin
                    mem_q[idx_s][k] <= wlane_s[k*8 +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign perr  = perr_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed vector table, hand-written reset/parity
// sequences and randomized traffic checked against a byte-array reference model.
module tb_data_mem_ctrl;

    localparam int W = 2;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        mem_rd, mem_wr, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic        busy, ready, err, perr;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mdl [0:511];
    logic [31:0] rd_exp;

    data_mem_ctrl #(.DEPTH_WORDS(128), .ADDR_W(7), .WAIT_CYCLES(W)) dut (
        .CLK(CLK), .Reset(Reset), .mem_rd(mem_rd), .mem_wr(mem_wr), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata),
        .busy(busy), .ready(ready), .err(err), .perr(perr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [1:0]  sz;
        bit          sx;
        logic [31:0] a;
        logic [31:0] wd;
        bit          e_err;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit rej(input bit rd, input bit wr, input logic [1:0] sz, input logic [31:0] a);
        return (rd && wr) || (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] sz, input bit sx, input logic [31:0] a);
        int p;
        int nb;
        int v;
        p  = int'(a[8:0]);
        nb = 1 << sz;
        v  = 0;
        for (int i = nb - 1; i >= 0; i--) v = (v << 8) | int'(mdl[p + i]);
        if (sx && nb < 4 && v >= (1 << (8 * nb - 1))) v = v - (1 << (8 * nb));
        return 32'(v);
    endfunction

    task automatic model_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int p;
        p = int'(a[8:0]);
        for (int i = 0; i < (1 << sz); i++) mdl[p + i] = wd[8*i +: 8];
    endtask

    function automatic logic [31:0] init_word(input int i);
        return {8'(i), 8'(~i), 8'(i * 3), 8'(i ^ 8'h5A)};
    endfunction

    // Issue one request (possibly from the DONE cycle), scramble inputs while busy, check timing and result.
    task automatic do_req(input bit rd, input bit wr, input logic [1:0] sz, input bit sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] got_rd, output logic got_err);
        bit rj;
        int n;
        rj = rej(rd, wr, sz, a);
        mem_rd = rd; mem_wr = wr; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge CLK); #1;
        mem_rd = 1'b0; mem_wr = 1'b0;
        addr = $urandom; wdata = $urandom; size = 2'($urandom_range(3, 0)); sign_ext = 1'($urandom_range(1, 0));
        if (!rj) begin
            if (wr) model_write(sz, a, wd);
            else rd_exp = model_read(sz, sx, a);
        end
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            chk("busy_while_wait", busy, 1'b1);
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 40) chk("ready_timeout", 32'(n), 32'd0);
        chk("latency", 32'(n), rj ? 32'd0 : 32'(W));
        chk("busy_at_ready", busy, 1'b0);
        chk("err", err, rj);
        chk("perr", perr, 1'b0);
        chk("rdata", rdata, rd_exp);
        got_rd = rdata;
        got_err = err;
    endtask

    initial begin
        logic [31:0] got;
        logic        gerr;
        int          n;
        int          r;
        logic [1:0]  sz;
        logic [31:0] a;

        tbl[0]  = '{0, 1, 2'd2, 0, 32'h10,  32'h8899AABB, 0, 32'h00000000};
        tbl[1]  = '{1, 0, 2'd2, 0, 32'h10,  32'h0,        0, 32'h8899AABB};
        tbl[2]  = '{1, 0, 2'd0, 1, 32'h13,  32'h0,        0, 32'hFFFFFF88};
        tbl[3]  = '{1, 0, 2'd0, 0, 32'h12,  32'h0,        0, 32'h00000099};
        tbl[4]  = '{1, 0, 2'd1, 1, 32'h12,  32'h0,        0, 32'hFFFF8899};
        tbl[5]  = '{0, 1, 2'd1, 0, 32'h11,  32'h0000DEAD, 1, 32'hFFFF8899};
        tbl[6]  = '{1, 0, 2'd2, 0, 32'h10,  32'h0,        0, 32'h8899AABB};
        tbl[7]  = '{1, 1, 2'd2, 0, 32'h10,  32'h0,        1, 32'h8899AABB};
        tbl[8]  = '{1, 0, 2'd3, 0, 32'h14,  32'h0,        1, 32'h8899AABB};
        tbl[9]  = '{1, 0, 2'd2, 0, 32'h12,  32'h0,        1, 32'h8899AABB};
        tbl[10] = '{1, 0, 2'd1, 0, 32'h10,  32'h0,        0, 32'h0000AABB};
        tbl[11] = '{1, 0, 2'd2, 0, 32'h210, 32'h0,        0, 32'h8899AABB};
        tbl[12] = '{1, 0, 2'd0, 1, 32'h11,  32'h0,        0, 32'hFFFFFFAA};

        Reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; size = 2'd0; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0; rd_exp = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ready", ready, 1'b0);
        chk("reset_err", err, 1'b0);
        chk("reset_perr", perr, 1'b0);
        Reset = 1'b0;

        // fill every word so the model is fully defined
        for (int i = 0; i < 128; i++) do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'(i * 4), init_word(i), got, gerr);

        for (int i = 0; i < 13; i++) begin
            do_req(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].sx, tbl[i].a, tbl[i].wd, got, gerr);
            chk($sformatf("vec%0d_err", i), gerr, tbl[i].e_err);
            chk($sformatf("vec%0d_rdata", i), got, tbl[i].e_rd);
        end

        // reset during the wait states of a store: write must be dropped
        repeat (2) @(posedge CLK);
        #1;
        mem_wr = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'h12345678;
        @(posedge CLK); #1;
        mem_wr = 1'b0;
        chk("rst_mid_busy_before", busy, 1'b1);
        Reset = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b0;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_ready", ready, 1'b0);
        chk("rst_mid_rdata", rdata, 32'h0);
        rd_exp = 32'h0;
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, got, gerr);
        chk("rst_old_contents", got, init_word(8));

        // randomized traffic, with occasional idle gaps
        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(15, 0);
            sz = 2'($urandom_range(3, 0));
            a  = $urandom;
            if ($urandom_range(3, 0) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            do_req(r == 0 || r < 8, r == 0 || r >= 8, sz, 1'($urandom_range(1, 0)), a, $urandom, got, gerr);
            if ($urandom_range(3, 0) == 0) begin
                @(posedge CLK); #1;
                chk("idle_ready", ready, 1'b0);
                chk("idle_busy", busy, 1'b0);
            end
        end

`ifdef DMEM_PARITY_EN
        do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABB, got, gerr);
        dut.par_q[4][0] = ~dut.par_q[4][0];
        mem_rd = 1'b1; size = 2'd2; sign_ext = 1'b0; addr = 32'h10;
        @(posedge CLK); #1;
        mem_rd = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("par_latency", 32'(n), 32'(W));
        chk("par_perr", perr, 1'b1);
        chk("par_rdata", rdata, 32'h8899AABB);
`else
        n = 0;
        chk("noparity_perr", perr, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
